// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the instruction-bus handshake,
// buffers one instruction for the hazard unit, and applies delayed redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall_f,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ireq_valid,
  output logic [31:0] ireq_addr,
  input  logic        iresp_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        i_valid,
  output logic        i_data_ok,
  output logic [31:0] pc_f,
  output logic [31:0] inst_f
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [31:0] inst_buf;
  logic        pend_redirect;
  logic [31:0] pend_pc;

  logic        complete;
  logic        advance;
  logic [31:0] next_pc;

  // complete/i_data_ok are built only from state and bus signals so the
  // hazard unit can feed stall_f back without a combinational loop.
  always_comb begin
    state_nxt = state;
    complete  = 1'b0;
    advance   = 1'b0;
    next_pc   = redirect_valid ? redirect_pc : (pend_redirect ? pend_pc : pc + 32'd4);
    case (state)
      S_REQ: begin
        if (iresp_addr_ok && iresp_data_ok) begin
          complete  = 1'b1;
          advance   = ~stall_f;
          state_nxt = stall_f ? S_HOLD : S_REQ;
        end else if (iresp_addr_ok) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (iresp_data_ok) begin
          complete  = 1'b1;
          advance   = ~stall_f;
          state_nxt = stall_f ? S_HOLD : S_REQ;
        end
      end
      S_HOLD: begin
        if (!stall_f) begin
          advance   = 1'b1;
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= S_REQ;
      pc            <= RESET_PC;
      inst_buf      <= 32'd0;
      pend_redirect <= 1'b0;
      pend_pc       <= 32'd0;
    end else begin
      state <= state_nxt;
      if (complete) inst_buf <= iresp_data;
      if (advance) pc <= next_pc;
      // The instruction in F at redirect time is the delay slot, so the
      // target is parked until that slot completes and the PC moves on.
      if (advance) begin
        pend_redirect <= 1'b0;
      end else if (redirect_valid) begin
        pend_redirect <= 1'b1;
        pend_pc       <= redirect_pc;
      end
    end
  end

  assign ireq_valid = (state == S_REQ);
  assign ireq_addr  = pc;
  assign i_valid    = 1'b1;
  assign i_data_ok  = (state == S_HOLD) | complete;
  assign pc_f       = pc;
  assign inst_f     = complete ? iresp_data : inst_buf;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit: per-cycle vectors plus an
// asynchronous reset sequence in mid-fetch.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        stall_f;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        i_valid;
  logic        i_data_ok;
  logic [31:0] pc_f;
  logic [31:0] inst_f;

  int total = 0;
  int bad   = 0;

  fetch_unit #(.RESET_PC(32'hbfc0_0000)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .stall_f       (stall_f),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .iresp_addr_ok (iresp_addr_ok),
    .iresp_data_ok (iresp_data_ok),
    .iresp_data    (iresp_data),
    .i_valid       (i_valid),
    .i_data_ok     (i_data_ok),
    .pc_f          (pc_f),
    .inst_f        (inst_f)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        st;
    logic        ao;
    logic        dok;
    logic [31:0] data;
    logic        e_rq;
    logic [31:0] e_addr;
    logic        e_ok;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic rv, input logic [31:0] rpc, input logic st,
                     input logic ao, input logic dok, input logic [31:0] data,
                     input logic e_rq, input logic [31:0] e_addr, input logic e_ok,
                     input logic [31:0] e_pc, input logic [31:0] e_inst);
    vq.push_back('{rv, rpc, st, ao, dok, data, e_rq, e_addr, e_ok, e_pc, e_inst});
  endtask

  task automatic idle_inputs();
    stall_f        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    iresp_addr_ok  = 1'b0;
    iresp_data_ok  = 1'b0;
    iresp_data     = 32'd0;
  endtask

  initial begin
    // rv rpc st ao dok data | rq addr ok pc inst
    // zero-wait bus: one instruction per cycle
    add(0, 0, 0, 1, 1, 32'h11111111, 1, 32'hbfc00000, 1, 32'hbfc00000, 32'h11111111);
    add(0, 0, 0, 1, 1, 32'h22222222, 1, 32'hbfc00004, 1, 32'hbfc00004, 32'h22222222);
    add(0, 0, 0, 1, 1, 32'h33333333, 1, 32'hbfc00008, 1, 32'hbfc00008, 32'h33333333);
    // addr_ok then data_ok three cycles later
    add(0, 0, 0, 1, 0, 32'h0,        1, 32'hbfc0000c, 0, 32'hbfc0000c, 32'h0);
    add(0, 0, 0, 0, 0, 32'h0,        0, 32'hbfc0000c, 0, 32'hbfc0000c, 32'h0);
    add(0, 0, 0, 0, 0, 32'h0,        0, 32'hbfc0000c, 0, 32'hbfc0000c, 32'h0);
    add(0, 0, 0, 0, 1, 32'h44444444, 0, 32'hbfc0000c, 1, 32'hbfc0000c, 32'h44444444);
    // stall three cycles starting at completion, then pc+4
    add(0, 0, 1, 1, 1, 32'h2402000a, 1, 32'hbfc00010, 1, 32'hbfc00010, 32'h2402000a);
    add(0, 0, 1, 0, 0, 32'h0,        0, 32'hbfc00010, 1, 32'hbfc00010, 32'h2402000a);
    add(0, 0, 1, 0, 0, 32'h0,        0, 32'hbfc00010, 1, 32'hbfc00010, 32'h2402000a);
    add(0, 0, 0, 0, 0, 32'h0,        0, 32'hbfc00010, 1, 32'hbfc00010, 32'h2402000a);
    add(0, 0, 0, 1, 0, 32'h0,        1, 32'hbfc00014, 0, 32'hbfc00014, 32'h0);
    // redirect while in WAIT: delay slot completes, then target
    add(1, 32'hbfc00100, 0, 0, 0, 32'h0, 0, 32'hbfc00014, 0, 32'hbfc00014, 32'h0);
    add(0, 0, 0, 0, 1, 32'h55555555, 0, 32'hbfc00014, 1, 32'hbfc00014, 32'h55555555);
    add(0, 0, 0, 1, 0, 32'h0,        1, 32'hbfc00100, 0, 32'hbfc00100, 32'h0);
    // pending redirect overridden by one in the completion cycle
    add(1, 32'hbfc00100, 0, 0, 0, 32'h0, 0, 32'hbfc00100, 0, 32'hbfc00100, 32'h0);
    add(1, 32'hbfc00200, 0, 0, 1, 32'h66666666, 0, 32'hbfc00100, 1, 32'hbfc00100, 32'h66666666);
    add(0, 0, 0, 1, 1, 32'h77777777, 1, 32'hbfc00200, 1, 32'hbfc00200, 32'h77777777);
    add(0, 0, 0, 1, 0, 32'h0,        1, 32'hbfc00204, 0, 32'hbfc00204, 32'h0);
    // two redirects while pending: last one wins
    add(1, 32'hbfc00400, 0, 0, 0, 32'h0, 0, 32'hbfc00204, 0, 32'hbfc00204, 32'h0);
    add(1, 32'hbfc00500, 0, 0, 0, 32'h0, 0, 32'hbfc00204, 0, 32'hbfc00204, 32'h0);
    add(0, 0, 0, 0, 1, 32'h88888888, 0, 32'hbfc00204, 1, 32'hbfc00204, 32'h88888888);
    add(0, 0, 0, 1, 0, 32'h0,        1, 32'hbfc00500, 0, 32'hbfc00500, 32'h0);
    add(0, 0, 0, 0, 1, 32'h99999999, 0, 32'hbfc00500, 1, 32'hbfc00500, 32'h99999999);
    // request address held without addr_ok despite redirect and stall
    add(1, 32'hbfc00600, 0, 0, 0, 32'h0, 1, 32'hbfc00504, 0, 32'hbfc00504, 32'h0);
    add(0, 0, 1, 0, 0, 32'h0,        1, 32'hbfc00504, 0, 32'hbfc00504, 32'h0);
    add(0, 0, 0, 1, 1, 32'haaaaaaaa, 1, 32'hbfc00504, 1, 32'hbfc00504, 32'haaaaaaaa);
    add(0, 0, 0, 1, 0, 32'h0,        1, 32'hbfc00600, 0, 32'hbfc00600, 32'h0);
    // pc+4 wraps through zero
    add(1, 32'hfffffffc, 0, 0, 1, 32'hbbbbbbbb, 0, 32'hbfc00600, 1, 32'hbfc00600, 32'hbbbbbbbb);
    add(0, 0, 0, 1, 1, 32'hcccccccc, 1, 32'hfffffffc, 1, 32'hfffffffc, 32'hcccccccc);
    add(0, 0, 0, 1, 0, 32'h0,        1, 32'h00000000, 0, 32'h00000000, 32'h0);

    idle_inputs();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_ireq_valid", {31'd0, ireq_valid}, 32'd1);
    chk("rst_ireq_addr",  ireq_addr,  32'hbfc00000);
    chk("rst_i_valid",    {31'd0, i_valid}, 32'd1);
    chk("rst_i_data_ok",  {31'd0, i_data_ok}, 32'd0);
    chk("rst_pc_f",       pc_f,   32'hbfc00000);
    chk("rst_inst_f",     inst_f, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      redirect_valid = vq[i].rv;
      redirect_pc    = vq[i].rpc;
      stall_f        = vq[i].st;
      iresp_addr_ok  = vq[i].ao;
      iresp_data_ok  = vq[i].dok;
      iresp_data     = vq[i].data;
      #1;
      chk($sformatf("v%0d_ireq_valid", i), {31'd0, ireq_valid}, {31'd0, vq[i].e_rq});
      chk($sformatf("v%0d_ireq_addr", i), ireq_addr, vq[i].e_addr);
      chk($sformatf("v%0d_i_valid", i), {31'd0, i_valid}, 32'd1);
      chk($sformatf("v%0d_i_data_ok", i), {31'd0, i_data_ok}, {31'd0, vq[i].e_ok});
      chk($sformatf("v%0d_pc_f", i), pc_f, vq[i].e_pc);
      if (vq[i].e_ok) chk($sformatf("v%0d_inst_f", i), inst_f, vq[i].e_inst);
      @(posedge clk);
      @(negedge clk);
    end

    // asynchronous reset while the fetch at 0 sits in WAIT
    idle_inputs();
    #1;
    chk("wait_ireq_valid", {31'd0, ireq_valid}, 32'd0);
    #1;
    resetn = 1'b0;
    #1;
    chk("arst_ireq_valid", {31'd0, ireq_valid}, 32'd1);
    chk("arst_ireq_addr",  ireq_addr, 32'hbfc00000);
    chk("arst_pc_f",       pc_f, 32'hbfc00000);
    chk("arst_i_data_ok",  {31'd0, i_data_ok}, 32'd0);
    chk("arst_inst_f",     inst_f, 32'd0);
    @(posedge clk);
    @(negedge clk);
    resetn        = 1'b1;
    iresp_addr_ok = 1'b1;
    #1;
    chk("post_rst_ireq_valid", {31'd0, ireq_valid}, 32'd1);
    chk("post_rst_ireq_addr",  ireq_addr, 32'hbfc00000);
    @(posedge clk);
    @(negedge clk);
    iresp_addr_ok = 1'b0;
    iresp_data_ok = 1'b1;
    iresp_data    = 32'hdddddddd;
    #1;
    chk("post_rst_i_data_ok", {31'd0, i_data_ok}, 32'd1);
    chk("post_rst_inst_f",    inst_f, 32'hdddddddd);
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("post_rst_next_addr", ireq_addr, 32'hbfc00004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
